decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Pipeline stage directly downstream of instruction fetch. Accepts the fetched RV32I word and its PC, and registers the decoded fields, sign-extended immediate and control signals for execute.
- Owns a per-register scoreboard that replaces cycle-count stalling in fetch. `fetch_hold` is the PC-enable gate back to fetch.

Parameters:
- IM_DEPTH, 256, instruction memory depth in words; PC width is `$clog2(IM_DEPTH<<2)`.
- WB_LATENCY, 3, cycles from issue until the destination register is readable; must be 1–15.

Ports:
- clk_100MHz  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset; clears all state immediately on assertion.
- instruction_fetched  input  32  instruction word from fetch.
- pc_fetched  input  PC_W  byte address of `instruction_fetched`.
- valid_in  input  1  fetch presents a real instruction.
- stall_in  input  1  execute cannot accept; hold the output registers.
- flush  input  1  squash the instruction in decode (taken branch or jump).
- fetch_hold  output  1  combinational; fetch must hold PC and instruction when 1.
- valid_d  output  1  output registers carry an issued instruction.
- pc_d  output  PC_W  registered PC.
- rd_d, rs1_d, rs2_d  output  5 each  registered register addresses.
- funct3_d  output  3  registered funct3.
- funct7_d  output  7  registered funct7.
- imm_d  output  32  registered sign-extended immediate.
- reg_write_d, mem_read_d, mem_write_d, alu_src_imm_d, branch_d, jump_d, illegal_d  output  1 each  registered control signals.

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0 and all scoreboard counters 0. `fetch_hold` evaluates to 0 while `valid_in`=0.
- Decoding is by `opcode` [6:0]; each class sets the listed controls, all others are 0.
  - R 0110011: reg_write.
  - I 0010011: reg_write, alu_src_imm.
  - LOAD 0000011: reg_write, mem_read, alu_src_imm.
  - STORE 0100011: mem_write, alu_src_imm.
  - BRANCH 1100011: branch.
  - JAL 1101111: reg_write, jump.
  - JALR 1100111: reg_write, jump, alu_src_imm.
  - LUI 0110111: reg_write, alu_src_imm.
  - AUIPC 0010111: reg_write, alu_src_imm.
  - Any other opcode: illegal=1, all other controls 0, instruction still issued.
- Immediates, all sign-extended from bit 31:
  - I: [31:20].
  - S: {[31:25],[11:7]}.
  - B: {[31],[7],[30:25],[11:8],0}.
  - U: {[31:12],12'b0}, no extension needed.
  - J: {[31],[19:12],[20],[30:21],0}.
  - R and illegal: 0.
- Source use:
  - rs1 is used by R, I, LOAD, STORE, BRANCH, JALR.
  - rs2 is used by R, STORE, BRANCH.
  - A source at x0 never hazards.
- Scoreboard:
  - Each of x1..x31 has a busy counter of width `$clog2(WB_LATENCY+1)`; x0 has none.
  - `hazard` = `valid_in` & (rs1 used & busy[rs1]≠0 | rs2 used & busy[rs2]≠0).
- Handshake and issue:
  - `fetch_hold` = `valid_in` & (`hazard` | `stall_in`).
  - Issue condition: `valid_in` & ~`hazard` & ~`stall_in` & ~`flush`.
  - On issue, next edge: output registers load, `valid_d`=1, latency 1 cycle.
  - On issue with reg_write and rd≠0: busy[rd] loads WB_LATENCY. This overrides any decrement of that counter in the same cycle.
- Counter decrement: when `stall_in`=0, every nonzero counter not being reloaded decrements by 1 per cycle, saturating at 0. When `stall_in`=1, all counters freeze.
- Bubble: `hazard` with `stall_in`=0 and `flush`=0 → next edge `valid_d`=0, data outputs hold their previous values.
- Downstream stall: `stall_in`=1 → all output registers, including `valid_d`, hold.
- Flush: `flush`=1 → next edge `valid_d`=0 regardless of `stall_in`, no issue, no scoreboard load. Existing counters still follow the decrement rule. Flush has priority over stall and hazard.
- An instruction reading and writing the same busy register stalls until the counter reaches 0, then reloads it on issue.
- Reset asserted mid-stall: `valid_d`=0 and counters clear immediately. The first instruction after release issues with no hazard.

Test Plan:
- Independent stream: `addi x1,x0,5` (0x00500093) then `addi x2,x0,7`, `valid_in`=1 → `valid_d`=1 each cycle, `imm_d`=5 then 7, `fetch_hold`=0 throughout.
- RAW hazard, WB_LATENCY=3: `addi x1,x0,5` then `add x3,x1,x1` → after x1 issues, busy[x1]=3; `fetch_hold`=1 for exactly 3 cycles with 3 bubbles; `add` issues on the 4th cycle.
- Immediate encoding: `sw x2,-4(x1)` (0xFE20AE23) → `imm_d`=0xFFFFFFFC, `mem_write_d`=1, `reg_write_d`=0. `jal x1,-8` (0xFF9FF0EF) → `imm_d`=0xFFFFFFF8, `jump_d`=1.
- x0 and illegal handling: `addi x0,x0,1` then `add x5,x0,x0` → no hazard. Word 0xFFFFFFFF → `illegal_d`=1, all other controls 0.
- Stall and flush: `stall_in`=1 for 2 cycles with busy[x1]=2 → outputs and counter hold, then decrement after release. `flush`=1 with a valid instruction → `valid_d`=0 next cycle and busy unchanged for its rd.
- Asynchronous reset: assert reset=0 mid-cycle while busy[x4]=2 → `valid_d` drops before the next edge. After release, `add x6,x4,x4` issues without a hazard.

Source files
------------

// File: rtl/decode_stage.sv
// RV32I decode stage: registers decoded fields, immediate and controls for execute,
// and tracks in-flight destination registers with per-register writeback counters.
module decode_stage #(
  parameter  int IM_DEPTH   = 256,
  parameter  int WB_LATENCY = 3,
  localparam int PC_W       = $clog2(IM_DEPTH << 2)
) (
  input  logic            clk_100MHz,
  input  logic            reset,
  input  logic [31:0]     instruction_fetched,
  input  logic [PC_W-1:0] pc_fetched,
  input  logic            valid_in,
  input  logic            stall_in,
  input  logic            flush,
  output logic            fetch_hold,
  output logic            valid_d,
  output logic [PC_W-1:0] pc_d,
  output logic [4:0]      rd_d,
  output logic [4:0]      rs1_d,
  output logic [4:0]      rs2_d,
  output logic [2:0]      funct3_d,
  output logic [6:0]      funct7_d,
  output logic [31:0]     imm_d,
  output logic            reg_write_d,
  output logic            mem_read_d,
  output logic            mem_write_d,
  output logic            alu_src_imm_d,
  output logic            branch_d,
  output logic            jump_d,
  output logic            illegal_d
);

  localparam int CNT_W = $clog2(WB_LATENCY + 1);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // Instruction field slices
  logic [6:0]  w_opcode;
  logic [4:0]  w_rd;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic [2:0]  w_funct3;
  logic [6:0]  w_funct7;

  assign w_opcode = instruction_fetched[6:0];
  assign w_rd     = instruction_fetched[11:7];
  assign w_funct3 = instruction_fetched[14:12];
  assign w_rs1    = instruction_fetched[19:15];
  assign w_rs2    = instruction_fetched[24:20];
  assign w_funct7 = instruction_fetched[31:25];

  logic [31:0] w_imm_i;
  logic [31:0] w_imm_s;
  logic [31:0] w_imm_b;
  logic [31:0] w_imm_u;
  logic [31:0] w_imm_j;

  assign w_imm_i = {{20{instruction_fetched[31]}}, instruction_fetched[31:20]};
  assign w_imm_s = {{20{instruction_fetched[31]}}, instruction_fetched[31:25],
                    instruction_fetched[11:7]};
  assign w_imm_b = {{19{instruction_fetched[31]}}, instruction_fetched[31],
                    instruction_fetched[7], instruction_fetched[30:25],
                    instruction_fetched[11:8], 1'b0};
  assign w_imm_u = {instruction_fetched[31:12], 12'b0};
  assign w_imm_j = {{11{instruction_fetched[31]}}, instruction_fetched[31],
                    instruction_fetched[19:12], instruction_fetched[20],
                    instruction_fetched[30:21], 1'b0};

  logic        w_reg_write;
  logic        w_mem_read;
  logic        w_mem_write;
  logic        w_alu_src_imm;
  logic        w_branch;
  logic        w_jump;
  logic        w_illegal;
  logic        w_rs1_used;
  logic        w_rs2_used;
  logic [31:0] w_imm;

  always_comb begin
    w_reg_write   = 1'b0;
    w_mem_read    = 1'b0;
    w_mem_write   = 1'b0;
    w_alu_src_imm = 1'b0;
    w_branch      = 1'b0;
    w_jump        = 1'b0;
    w_illegal     = 1'b0;
    w_rs1_used    = 1'b0;
    w_rs2_used    = 1'b0;
    w_imm         = 32'd0;
    case (w_opcode)
      OP_R: begin
        w_reg_write = 1'b1;
        w_rs1_used  = 1'b1;
        w_rs2_used  = 1'b1;
      end
      OP_I: begin
        w_reg_write   = 1'b1;
        w_alu_src_imm = 1'b1;
        w_rs1_used    = 1'b1;
        w_imm         = w_imm_i;
      end
      OP_LOAD: begin
        w_reg_write   = 1'b1;
        w_mem_read    = 1'b1;
        w_alu_src_imm = 1'b1;
        w_rs1_used    = 1'b1;
        w_imm         = w_imm_i;
      end
      OP_STORE: begin
        w_mem_write   = 1'b1;
        w_alu_src_imm = 1'b1;
        w_rs1_used    = 1'b1;
        w_rs2_used    = 1'b1;
        w_imm         = w_imm_s;
      end
      OP_BRANCH: begin
        w_branch   = 1'b1;
        w_rs1_used = 1'b1;
        w_rs2_used = 1'b1;
        w_imm      = w_imm_b;
      end
      OP_JAL: begin
        w_reg_write = 1'b1;
        w_jump      = 1'b1;
        w_imm       = w_imm_j;
      end
      OP_JALR: begin
        w_reg_write   = 1'b1;
        w_jump        = 1'b1;
        w_alu_src_imm = 1'b1;
        w_rs1_used    = 1'b1;
        w_imm         = w_imm_i;
      end
      OP_LUI, OP_AUIPC: begin
        w_reg_write   = 1'b1;
        w_alu_src_imm = 1'b1;
        w_imm         = w_imm_u;
      end
      default: begin
        w_illegal = 1'b1;
      end
    endcase
  end

  // Scoreboard: bit 0 (x0) is tied low so x0 sources never hazard
  logic [31:0] w_busy_nz;
  logic        w_hazard;
  logic        w_issue;

  assign w_busy_nz[0] = 1'b0;
  assign w_hazard = valid_in & ((w_rs1_used & w_busy_nz[w_rs1]) |
                                (w_rs2_used & w_busy_nz[w_rs2]));
  assign w_issue  = valid_in & ~w_hazard & ~stall_in & ~flush;
  assign fetch_hold = valid_in & (w_hazard | stall_in);

  genvar gi;
  generate
    for (gi = 1; gi < 32; gi++) begin : g_busy
      logic [CNT_W-1:0] r_cnt;
      logic             w_load;

      assign w_load = w_issue & w_reg_write & (w_rd == 5'(gi));
      assign w_busy_nz[gi] = |r_cnt;

      // A reload on issue wins over the decrement; stall freezes everything else
      always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
          r_cnt <= '0;
        end else if (w_load) begin
          r_cnt <= CNT_W'(WB_LATENCY);
        end else if (!stall_in && (r_cnt != '0)) begin
          r_cnt <= r_cnt - CNT_W'(1);
        end
      end
    end
  endgenerate

  logic            r_valid_d;
  logic [PC_W-1:0] r_pc_d;
  logic [4:0]      r_rd_d;
  logic [4:0]      r_rs1_d;
  logic [4:0]      r_rs2_d;
  logic [2:0]      r_funct3_d;
  logic [6:0]      r_funct7_d;
  logic [31:0]     r_imm_d;
  logic [6:0]      r_ctrl_d;

  // Flush beats stall; a bubble clears valid but leaves the data fields untouched
  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      r_valid_d  <= 1'b0;
      r_pc_d     <= '0;
      r_rd_d     <= '0;
      r_rs1_d    <= '0;
      r_rs2_d    <= '0;
      r_funct3_d <= '0;
      r_funct7_d <= '0;
      r_imm_d    <= '0;
      r_ctrl_d   <= '0;
    end else if (flush) begin
      r_valid_d <= 1'b0;
    end else if (!stall_in) begin
      r_valid_d <= w_issue;
      if (w_issue) begin
        r_pc_d     <= pc_fetched;
        r_rd_d     <= w_rd;
        r_rs1_d    <= w_rs1;
        r_rs2_d    <= w_rs2;
        r_funct3_d <= w_funct3;
        r_funct7_d <= w_funct7;
        r_imm_d    <= w_imm;
        r_ctrl_d   <= {w_reg_write, w_mem_read, w_mem_write, w_alu_src_imm,
                       w_branch, w_jump, w_illegal};
      end
    end
  end

  assign valid_d       = r_valid_d;
  assign pc_d          = r_pc_d;
  assign rd_d          = r_rd_d;
  assign rs1_d         = r_rs1_d;
  assign rs2_d         = r_rs2_d;
  assign funct3_d      = r_funct3_d;
  assign funct7_d      = r_funct7_d;
  assign imm_d         = r_imm_d;
  assign reg_write_d   = r_ctrl_d[6];
  assign mem_read_d    = r_ctrl_d[5];
  assign mem_write_d   = r_ctrl_d[4];
  assign alu_src_imm_d = r_ctrl_d[3];
  assign branch_d      = r_ctrl_d[2];
  assign jump_d        = r_ctrl_d[1];
  assign illegal_d     = r_ctrl_d[0];

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode vector table plus hazard, stall, flush
// and asynchronous reset sequences.
module tb_decode_stage;
  localparam int PC_W = 10;

  logic            clk_100MHz = 1'b0;
  logic            reset;
  logic [31:0]     instruction_fetched;
  logic [PC_W-1:0] pc_fetched;
  logic            valid_in;
  logic            stall_in;
  logic            flush;
  logic            fetch_hold;
  logic            valid_d;
  logic [PC_W-1:0] pc_d;
  logic [4:0]      rd_d, rs1_d, rs2_d;
  logic [2:0]      funct3_d;
  logic [6:0]      funct7_d;
  logic [31:0]     imm_d;
  logic            reg_write_d, mem_read_d, mem_write_d, alu_src_imm_d;
  logic            branch_d, jump_d, illegal_d;

  always #5 clk_100MHz = ~clk_100MHz;

  decode_stage #(.IM_DEPTH(256), .WB_LATENCY(3)) dut (
    .clk_100MHz(clk_100MHz), .reset(reset),
    .instruction_fetched(instruction_fetched), .pc_fetched(pc_fetched),
    .valid_in(valid_in), .stall_in(stall_in), .flush(flush),
    .fetch_hold(fetch_hold), .valid_d(valid_d), .pc_d(pc_d),
    .rd_d(rd_d), .rs1_d(rs1_d), .rs2_d(rs2_d),
    .funct3_d(funct3_d), .funct7_d(funct7_d), .imm_d(imm_d),
    .reg_write_d(reg_write_d), .mem_read_d(mem_read_d), .mem_write_d(mem_write_d),
    .alu_src_imm_d(alu_src_imm_d), .branch_d(branch_d), .jump_d(jump_d),
    .illegal_d(illegal_d)
  );

  typedef struct {
    logic [31:0] instr;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [6:0]  ctrl;  // {reg_write, mem_read, mem_write, alu_src_imm, branch, jump, illegal}
  } vec_t;

  vec_t vecs [12];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_100MHz);
    #1;
  endtask

  task automatic drive(input logic [31:0] ins, input logic v, input logic st, input logic fl);
    instruction_fetched = ins;
    valid_in = v;
    stall_in = st;
    flush    = fl;
  endtask

  task automatic drain();
    drive(32'h0, 1'b0, 1'b0, 1'b0);
    repeat (4) tick();
  endtask

  // Waits for the presented instruction to issue; returns hold and bubble counts
  task automatic wait_issue(output int holds, output int bubbles, output bit issued);
    holds = 0;
    bubbles = 0;
    issued = 1'b0;
    for (int c = 0; c < 10 && !issued; c++) begin
      #1;
      if (fetch_hold) holds++;
      tick();
      if (valid_d) issued = 1'b1;
      else bubbles++;
    end
  endtask

  function automatic logic [6:0] ctrl_out();
    return {reg_write_d, mem_read_d, mem_write_d, alu_src_imm_d, branch_d, jump_d, illegal_d};
  endfunction

  int  holds, bubbles;
  bit  issued;

  initial begin
    vecs[0]  = '{32'h00500093, 5'd1,  5'd0,  5'd5,  3'd0, 7'h00, 32'h00000005, 7'b1001000}; // addi x1,x0,5
    vecs[1]  = '{32'hFE20AE23, 5'd28, 5'd1,  5'd2,  3'd2, 7'h7F, 32'hFFFFFFFC, 7'b0011000}; // sw x2,-4(x1)
    vecs[2]  = '{32'hFF9FF0EF, 5'd1,  5'd31, 5'd25, 3'd7, 7'h7F, 32'hFFFFFFF8, 7'b1000010}; // jal x1,-8
    vecs[3]  = '{32'hFFFFFFFF, 5'd31, 5'd31, 5'd31, 3'd7, 7'h7F, 32'h00000000, 7'b0000001}; // illegal
    vecs[4]  = '{32'h001081B3, 5'd3,  5'd1,  5'd1,  3'd0, 7'h00, 32'h00000000, 7'b1000000}; // add x3,x1,x1
    vecs[5]  = '{32'h00812283, 5'd5,  5'd2,  5'd8,  3'd2, 7'h00, 32'h00000008, 7'b1101000}; // lw x5,8(x2)
    vecs[6]  = '{32'hFE2088E3, 5'd17, 5'd1,  5'd2,  3'd0, 7'h7F, 32'hFFFFFFF0, 7'b0000100}; // beq x1,x2,-16
    vecs[7]  = '{32'h123453B7, 5'd7,  5'd8,  5'd3,  3'd5, 7'h09, 32'h12345000, 7'b1001000}; // lui x7,0x12345
    vecs[8]  = '{32'h80000417, 5'd8,  5'd0,  5'd0,  3'd0, 7'h40, 32'h80000000, 7'b1001000}; // auipc x8,0x80000
    vecs[9]  = '{32'h004280E7, 5'd1,  5'd5,  5'd4,  3'd0, 7'h00, 32'h00000004, 7'b1001010}; // jalr x1,4(x5)
    vecs[10] = '{32'h00700113, 5'd2,  5'd0,  5'd7,  3'd0, 7'h00, 32'h00000007, 7'b1001000}; // addi x2,x0,7
    vecs[11] = '{32'hFFF00093, 5'd1,  5'd0,  5'd31, 3'd0, 7'h7F, 32'hFFFFFFFF, 7'b1001000}; // addi x1,x0,-1

    reset = 1'b0;
    pc_fetched = '0;
    drive(32'h0, 1'b0, 1'b0, 1'b0);
    #1;
    check("reset_valid", 32'(valid_d), 32'd0);
    check("reset_imm", imm_d, 32'd0);
    check("reset_ctrl", 32'(ctrl_out()), 32'd0);
    check("reset_hold", 32'(fetch_hold), 32'd0);
    #2 reset = 1'b1;
    tick();

    // Decode table
    for (int i = 0; i < 12; i++) begin
      drain();
      pc_fetched = 10'(i * 4);
      drive(vecs[i].instr, 1'b1, 1'b0, 1'b0);
      #1;
      check("tbl_hold", 32'(fetch_hold), 32'd0);
      tick();
      check("tbl_valid", 32'(valid_d), 32'd1);
      check("tbl_pc", 32'(pc_d), 32'(i * 4));
      check("tbl_rd", 32'(rd_d), 32'(vecs[i].rd));
      check("tbl_rs1", 32'(rs1_d), 32'(vecs[i].rs1));
      check("tbl_rs2", 32'(rs2_d), 32'(vecs[i].rs2));
      check("tbl_funct3", 32'(funct3_d), 32'(vecs[i].f3));
      check("tbl_funct7", 32'(funct7_d), 32'(vecs[i].f7));
      check("tbl_imm", imm_d, vecs[i].imm);
      check("tbl_ctrl", 32'(ctrl_out()), 32'(vecs[i].ctrl));
      $display("vec %0d instr=%08h imm_d=%08h ctrl=%07b", i, vecs[i].instr, imm_d, ctrl_out());
    end

    // Independent back-to-back stream
    drain();
    drive(32'h00500093, 1'b1, 1'b0, 1'b0);
    #1 check("ind_hold0", 32'(fetch_hold), 32'd0);
    tick();
    check("ind_valid0", 32'(valid_d), 32'd1);
    check("ind_imm0", imm_d, 32'd5);
    drive(32'h00700113, 1'b1, 1'b0, 1'b0);
    #1 check("ind_hold1", 32'(fetch_hold), 32'd0);
    tick();
    check("ind_valid1", 32'(valid_d), 32'd1);
    check("ind_imm1", imm_d, 32'd7);
    $display("independent stream done");

    // RAW hazard on x1
    drain();
    drive(32'h00500093, 1'b1, 1'b0, 1'b0);
    tick();
    drive(32'h001081B3, 1'b1, 1'b0, 1'b0);
    wait_issue(holds, bubbles, issued);
    check("raw_issued", 32'(issued), 32'd1);
    check("raw_holds", 32'(holds), 32'd3);
    check("raw_bubbles", 32'(bubbles), 32'd3);
    check("raw_rd", 32'(rd_d), 32'd3);
    $display("raw hazard: holds=%0d bubbles=%0d", holds, bubbles);

    // x0 writes and reads never hazard
    drain();
    drive(32'h00100013, 1'b1, 1'b0, 1'b0);
    tick();
    check("x0_valid0", 32'(valid_d), 32'd1);
    drive(32'h000002B3, 1'b1, 1'b0, 1'b0);
    #1 check("x0_hold", 32'(fetch_hold), 32'd0);
    tick();
    check("x0_valid1", 32'(valid_d), 32'd1);
    check("x0_rd", 32'(rd_d), 32'd5);
    $display("x0 sequence done");

    // Downstream stall with busy[x1]=2, then release
    drain();
    drive(32'h00500093, 1'b1, 1'b0, 1'b0);
    tick();
    drive(32'h00700113, 1'b1, 1'b0, 1'b0);
    tick();
    drive(32'h001081B3, 1'b1, 1'b1, 1'b0);
    #1 check("stall_hold", 32'(fetch_hold), 32'd1);
    for (int k = 0; k < 2; k++) begin
      tick();
      check("stall_valid", 32'(valid_d), 32'd1);
      check("stall_rd", 32'(rd_d), 32'd2);
      check("stall_imm", imm_d, 32'd7);
    end
    stall_in = 1'b0;
    wait_issue(holds, bubbles, issued);
    check("stall_rel_issued", 32'(issued), 32'd1);
    check("stall_rel_holds", 32'(holds), 32'd2);
    check("stall_rel_rd", 32'(rd_d), 32'd3);
    $display("stall release: holds=%0d bubbles=%0d", holds, bubbles);

    // Flush wins over stall, then flush alone; rd of the flushed instruction stays free
    drive(32'h00100213, 1'b1, 1'b1, 1'b1);
    tick();
    check("flush_stall_valid", 32'(valid_d), 32'd0);
    check("flush_stall_rd", 32'(rd_d), 32'd3);
    drive(32'h00100213, 1'b1, 1'b0, 1'b1);
    tick();
    check("flush_valid", 32'(valid_d), 32'd0);
    drive(32'h00420333, 1'b1, 1'b0, 1'b0);
    #1 check("flush_nohaz", 32'(fetch_hold), 32'd0);
    tick();
    check("flush_next_valid", 32'(valid_d), 32'd1);
    check("flush_next_rd", 32'(rd_d), 32'd6);
    $display("flush sequence done");

    // Asynchronous reset with busy[x4]=2
    drain();
    drive(32'h00100213, 1'b1, 1'b0, 1'b0);
    tick();
    drive(32'h00700113, 1'b1, 1'b0, 1'b0);
    tick();
    check("arst_pre_valid", 32'(valid_d), 32'd1);
    valid_in = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("arst_valid", 32'(valid_d), 32'd0);
    check("arst_imm", imm_d, 32'd0);
    check("arst_rd", 32'(rd_d), 32'd0);
    #2 reset = 1'b1;
    drive(32'h00420333, 1'b1, 1'b0, 1'b0);
    #1 check("arst_nohaz", 32'(fetch_hold), 32'd0);
    tick();
    check("arst_issue_valid", 32'(valid_d), 32'd1);
    check("arst_issue_rd", 32'(rd_d), 32'd6);
    $display("async reset sequence done");

    drive(32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
